// File: rtl/rr_arb_mux.sv
// N-input valid/ready multiplexer whose select comes from an internal round-robin
// arbiter, feeding a single registered output stage that sustains one beat per cycle.
module rr_arb_mux #(
  parameter int  N_INS     = 4,
  parameter int  WIDTH     = 32,
  localparam int SEL_WIDTH = $clog2(N_INS)
) (
  input  logic                            clk,
  input  logic                            rst_aL,
  input  logic [N_INS-1:0]                in_valid,
  input  logic [N_INS-1:0][WIDTH-1:0]     ins,
  output logic [N_INS-1:0]                in_ready,
  output logic                            out_valid,
  output logic [WIDTH-1:0]                out,
  output logic [SEL_WIDTH-1:0]            out_sel,
  input  logic                            out_ready
);

  // One spare bit so last_grant + offset never overflows before the modulo fold.
  localparam int                 CAND_WIDTH = SEL_WIDTH + 1;
  localparam logic [SEL_WIDTH:0] N_EXT      = CAND_WIDTH'(N_INS);
  localparam logic [SEL_WIDTH-1:0] LAST_INIT = SEL_WIDTH'(N_INS - 1);

  logic [SEL_WIDTH-1:0] last_grant;
  logic [SEL_WIDTH-1:0] grant_idx;
  logic                 grant_any;
  logic [SEL_WIDTH:0]   cand;
  logic [N_INS-1:0]     grant;
  logic                 can_load;
  logic                 load;

  assign can_load = !out_valid || out_ready;
  assign load     = grant_any && can_load;

  // Rotating priority search: channel last_grant+1 first, wrapping modulo N_INS.
  // NOTE: every variable assigned in always_comb gets a default at the top,
  // otherwise paths that skip an assignment infer a latch.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= N_INS; k++) begin
      cand = {1'b0, last_grant} + CAND_WIDTH'(k);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!grant_any && in_valid[cand[SEL_WIDTH-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[SEL_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    grant            = '0;
    grant[grant_idx] = grant_any;
  end

  // Gated by reset so no requester sees an accept while the block is held in reset.
  assign in_ready = grant & {N_INS{can_load && rst_aL}};

  // NOTE: state is written with non-blocking assignments so every register samples
  // pre-edge values; the datapath register is reset too because out=0 is observable.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      out_valid  <= 1'b0;
      out        <= '0;
      out_sel    <= '0;
      last_grant <= LAST_INIT;
    end else if (load) begin
      out_valid  <= 1'b1;
      out        <= ins[grant_idx];
      out_sel    <= grant_idx;
      last_grant <= grant_idx;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_aL)
    $onehot0(in_ready));

  a_stall_holds : assert property (@(posedge clk) disable iff (!rst_aL)
    (out_valid && !out_ready) |=> (out_valid && $stable(out) && $stable(out_sel)));

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed scenarios on a 4-input instance, random sweep on both
// a 4-input and a 64-input instance, checked by a reference model feeding scoreboards.
module tb_rr_arb_mux;

  typedef struct {
    logic [31:0] data;
    int          sel;
  } beat_t;

  logic clk = 1'b0;
  logic rst_aL = 1'b0;

  logic [3:0]        valid_a;
  logic [3:0][31:0]  ins_a;
  logic [3:0]        ready_in_a;
  logic              ov_a;
  logic [31:0]       out_a;
  logic [1:0]        sel_a;
  logic              ordy_a;

  logic [63:0]       valid_b;
  logic [63:0][31:0] ins_b;
  logic [63:0]       ready_in_b;
  logic              ov_b;
  logic [31:0]       out_b;
  logic [5:0]        sel_b;
  logic              ordy_b;

  int n_checks = 0;
  int n_errors = 0;

  beat_t qa[$];
  beat_t qb[$];
  int    ma_last = 3;
  bit    ma_full = 1'b0;
  int    mb_last = 63;
  bit    mb_full = 1'b0;
  int    waits[64];
  int    max_wait = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.N_INS(4), .WIDTH(32)) dut_a (
    .clk(clk), .rst_aL(rst_aL), .in_valid(valid_a), .ins(ins_a), .in_ready(ready_in_a),
    .out_valid(ov_a), .out(out_a), .out_sel(sel_a), .out_ready(ordy_a)
  );

  rr_arb_mux #(.N_INS(64), .WIDTH(32)) dut_b (
    .clk(clk), .rst_aL(rst_aL), .in_valid(valid_b), .ins(ins_b), .in_ready(ready_in_b),
    .out_valid(ov_b), .out(out_b), .out_sel(sel_b), .out_ready(ordy_b)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] got);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got beat %0h with no beat expected", name, got);
  endtask

  // Reference rule: first requester found scanning last+1, last+2, ... modulo n.
  function automatic int pick(input logic [63:0] v, input int n, input int last);
    for (int k = 1; k <= n; k++)
      if (v[(last + k) % n]) return (last + k) % n;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A reset discards any beat in flight, so the scoreboards and model restart.
  always @(negedge rst_aL) begin
    qa.delete();
    qb.delete();
    ma_last = 3;
    ma_full = 1'b0;
    mb_last = 63;
    mb_full = 1'b0;
    foreach (waits[i]) waits[i] = 0;
  end

  // Reference model: predicts the accept vector and the beat loaded at the next edge.
  always @(negedge clk) begin
    if (rst_aL) begin : model
      int         wa, wb;
      logic [3:0] exp_a;
      logic [63:0] exp_b;
      wa = (!ma_full || ordy_a) ? pick(64'(valid_a), 4, ma_last) : -1;
      exp_a = (wa >= 0) ? 4'(1 << wa) : 4'b0;
      check("a_in_ready", 64'(ready_in_a), 64'(exp_a));
      if (wa >= 0) begin
        qa.push_back('{ins_a[wa], wa});
        ma_last = wa;
        ma_full = 1'b1;
      end else if (ordy_a) begin
        ma_full = 1'b0;
      end
      wb = (!mb_full || ordy_b) ? pick(valid_b, 64, mb_last) : -1;
      exp_b = (wb >= 0) ? (64'd1 << wb) : 64'd0;
      check("b_in_ready", ready_in_b, exp_b);
      if (wb >= 0) begin
        qb.push_back('{ins_b[wb], wb});
        mb_last = wb;
        mb_full = 1'b1;
      end else if (ordy_b) begin
        mb_full = 1'b0;
      end
    end
  end

  // Monitor: every beat leaving the DUT is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rst_aL) begin : mon
      beat_t e;
      logic  xfer;
      if (ov_a && ordy_a) begin
        if (qa.size() == 0) unexpected("a_beat", out_a);
        else begin
          e = qa.pop_front();
          check("a_out", 64'(out_a), 64'(e.data));
          check("a_out_sel", 64'(sel_a), 64'(e.sel));
        end
      end
      if (ov_b && ordy_b) begin
        if (qb.size() == 0) unexpected("b_beat", out_b);
        else begin
          e = qb.pop_front();
          check("b_out", 64'(out_b), 64'(e.data));
          check("b_out_sel", 64'(sel_b), 64'(e.sel));
        end
      end
      xfer = |(valid_b & ready_in_b);
      for (int i = 0; i < 64; i++) begin
        if (!valid_b[i] || ready_in_b[i]) waits[i] = 0;
        else if (xfer) waits[i]++;
        if (waits[i] > max_wait) max_wait = waits[i];
      end
    end
  end

  initial begin
    valid_a = '0; ins_a = '0; ordy_a = 1'b0;
    valid_b = '0; ins_b = '0; ordy_b = 1'b0;

    // Reset state, with requests present to show in_ready is gated.
    #3;
    valid_a = 4'hF;
    #1;
    check("rst_in_ready", 64'(ready_in_a), 64'h0);
    check("rst_out_valid", 64'(ov_a), 64'h0);
    check("rst_out", 64'(out_a), 64'h0);
    check("rst_out_sel", 64'(sel_a), 64'h0);
    valid_a = 4'h0;
    @(posedge clk);
    #2 rst_aL = 1'b1;
    ordy_a = 1'b1;
    ordy_b = 1'b1;
    repeat (5) begin
      tick();
      check("idle_out_valid", 64'(ov_a), 64'h0);
      check("idle_in_ready", 64'(ready_in_a), 64'h0);
      check("idle_out", 64'(out_a), 64'h0);
    end

    // Single channel.
    valid_a = 4'b0100;
    ins_a[2] = 32'hDEADBEEF;
    #1;
    check("single_in_ready", 64'(ready_in_a), 64'h4);
    tick();
    check("single_out", 64'(out_a), 64'hDEADBEEF);
    check("single_out_sel", 64'(sel_a), 64'd2);
    check("single_out_valid", 64'(ov_a), 64'h1);
    valid_a = 4'b0000;
    tick();

    // Round-robin fairness from a fresh reset.
    rst_aL = 1'b0;
    #1 rst_aL = 1'b1;
    for (int i = 0; i < 4; i++) ins_a[i] = 32'(i * 2);
    valid_a = 4'hF;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rr_out_sel", 64'(sel_a), 64'(k % 4));
      check("rr_out", 64'(out_a), 64'(2 * (k % 4)));
      check("rr_out_valid", 64'(ov_a), 64'h1);
    end

    // Backpressure with channels 1 and 3 requesting.
    valid_a = 4'b1010;
    tick();
    check("bp_first_sel", 64'(sel_a), 64'd1);
    ordy_a = 1'b0;
    repeat (3) begin
      #1;
      check("bp_in_ready", 64'(ready_in_a), 64'h0);
      tick();
      check("bp_hold_sel", 64'(sel_a), 64'd1);
      check("bp_hold_out", 64'(out_a), 64'd2);
      check("bp_hold_valid", 64'(ov_a), 64'h1);
    end
    ordy_a = 1'b1;
    #1;
    check("bp_resume_ready", 64'(ready_in_a), 64'h8);
    tick();
    check("bp_second_sel", 64'(sel_a), 64'd3);
    tick();
    check("bp_third_sel", 64'(sel_a), 64'd1);

    // Wrap-around and skipping idle channels.
    valid_a = 4'b1000;
    tick();
    check("wrap_prime_sel", 64'(sel_a), 64'd3);
    valid_a = 4'b0010;
    tick();
    check("wrap_sel", 64'(sel_a), 64'd1);
    valid_a = 4'b1001;
    tick();
    check("skip_sel_3", 64'(sel_a), 64'd3);
    tick();
    check("skip_sel_0", 64'(sel_a), 64'd0);
    valid_a = 4'b0000;
    tick();

    // Asynchronous reset between edges while a beat is held.
    ordy_a = 1'b0;
    valid_a = 4'b0001;
    ins_a[0] = 32'h12345678;
    tick();
    check("async_pre_valid", 64'(ov_a), 64'h1);
    valid_a = 4'b0000;
    #1 rst_aL = 1'b0;
    #1;
    check("async_out_valid", 64'(ov_a), 64'h0);
    check("async_out", 64'(out_a), 64'h0);
    check("async_in_ready", 64'(ready_in_a), 64'h0);
    rst_aL = 1'b1;
    valid_a = 4'hF;
    ordy_a = 1'b1;
    #1;
    check("async_first_ready", 64'(ready_in_a), 64'h1);
    tick();
    check("async_first_sel", 64'(sel_a), 64'd0);
    check("async_first_out", 64'(out_a), 64'h12345678);

    // Random sweep on both instances.
    repeat (1000) begin
      valid_a = 4'($urandom);
      for (int i = 0; i < 4; i++) ins_a[i] = $urandom;
      ordy_a = ($urandom_range(0, 3) != 0);
      valid_b = {$urandom, $urandom} & {$urandom, $urandom};
      for (int i = 0; i < 64; i++) ins_b[i] = $urandom;
      ordy_b = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Drain and confirm nothing was lost.
    valid_a = '0;
    valid_b = '0;
    ordy_a = 1'b1;
    ordy_b = 1'b1;
    repeat (3) tick();
    check("a_scoreboard_empty", 64'(qa.size()), 64'd0);
    check("b_scoreboard_empty", 64'(qb.size()), 64'd0);
    check("b_max_wait_le_63", 64'(max_wait <= 63), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
